// File: rtl/reg_share_arb_if.sv
// Requester-side bus of reg_share_arb.
// The lock vector exists only when ARB_LOCK_EN is defined.
interface reg_share_arb_if #(
  parameter int N = 8,
  parameter int R = 4
);
  localparam int IW = $clog2(R);

  logic [R-1:0]   req;
  logic [R*N-1:0] din;
  logic [R-1:0]   gnt;
  logic [R-1:0]   ack;
  logic [N-1:0]   q;
  logic           q_valid;
  logic [IW-1:0]  owner;
  logic           busy;
`ifdef ARB_LOCK_EN
  logic [R-1:0]   lock;

  modport master (
    output req, din, lock,
    input  gnt, ack, q, q_valid, owner, busy
  );

  modport slave (
    input  req, din, lock,
    output gnt, ack, q, q_valid, owner, busy
  );
`else
  modport master (
    output req, din,
    input  gnt, ack, q, q_valid, owner, busy
  );

  modport slave (
    input  req, din,
    output gnt, ack, q, q_valid, owner, busy
  );
`endif
endinterface

// File: rtl/reg_share_arb.sv
// Round-robin arbiter sharing one N-bit register among R requesters.
// Define ARB_LOCK_EN to enable locked bursts of up to MAX_BURST writes.
module reg_share_arb #(
  parameter int N = 8,
  parameter int R = 4
`ifdef ARB_LOCK_EN
  , parameter int MAX_BURST = 4
`endif
) (
  input  logic           clk,
  input  logic           res_n,
  reg_share_arb_if.slave bus
);
  localparam int IW = $clog2(R);
  localparam logic [IW:0] RV = (IW+1)'(R);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ACK
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] id_q, id_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [R-1:0]  gnt_q, gnt_d;
  logic [R-1:0]  ack_q, ack_d;
  logic [N-1:0]  data_q, data_d;
  logic          vld_q, vld_d;
  logic [IW-1:0] sel;
  logic          hit;
  logic [IW:0]   j;
  logic          relock;

  // first request at or after last+1, wrapping
  always_comb begin
    sel = '0;
    hit = 1'b0;
    j   = '0;
    for (int k = 1; k <= R; k++) begin
      j = {1'b0, last_q} + (IW+1)'(k);
      if (j >= RV) j = j - RV;
      if (!hit && bus.req[j[IW-1:0]]) begin
        hit = 1'b1;
        sel = j[IW-1:0];
      end
    end
  end

`ifdef ARB_LOCK_EN
  localparam int BW = $clog2(MAX_BURST) + 1;

  logic [BW-1:0] burst_q, burst_d;

  assign relock = bus.lock[id_q] && bus.req[id_q]
               && (burst_q < BW'(MAX_BURST - 1));

  always_comb begin
    burst_d = burst_q;
    if (state_q == ACK) burst_d = relock ? burst_q + BW'(1) : '0;
    else if (state_q == IDLE) burst_d = '0;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) burst_q <= '0;
    else        burst_q <= burst_d;
  end
`else
  assign relock = 1'b0;
`endif

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hit) state_d = LOAD;
      LOAD:    state_d = ACK;
      ACK:     state_d = relock ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    id_d    = id_q;
    last_d  = last_q;
    owner_d = owner_q;
    data_d  = data_q;
    vld_d   = vld_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (hit) begin
          id_d  = sel;
          gnt_d = R'(1) << sel;
        end
      end
      LOAD: begin
        data_d  = bus.din[id_q*N +: N];
        vld_d   = 1'b1;
        owner_d = id_q;
        last_d  = id_q;
        ack_d   = R'(1) << id_q;
      end
      ACK:     if (!relock) gnt_d = '0;
      default: gnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      id_q    <= '0;
      last_q  <= IW'(R - 1);
      owner_q <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      id_q    <= id_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.ack     = ack_q;
  assign bus.q       = data_q;
  assign bus.q_valid = vld_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_reg_share_arb.sv
// Bench for reg_share_arb: directed cases plus random requesters
// checked against a transaction-level model.
module tb_reg_share_arb;
  localparam int N  = 8;
  localparam int R  = 4;
  localparam int MB = 4;
`ifdef ARB_LOCK_EN
  localparam int WMAX = (2*MB+1)*(R+1) + 6;
`else
  localparam int WMAX = 3*R + 6;
`endif

  logic clk = 1'b0;
  logic res_n = 1'b1;
  int   total = 0;
  int   bad = 0;
  bit   auto_en = 1'b0;
  int   wt [R];

  always #5 clk = ~clk;

  reg_share_arb_if #(.N(N), .R(R)) bus ();

  reg_share_arb #(
    .N(N),
    .R(R)
`ifdef ARB_LOCK_EN
    , .MAX_BURST(MB)
`endif
  ) dut (
    .clk  (clk),
    .res_n(res_n),
    .bus  (bus)
  );

  // reference: one transaction = grant, one or more writes, release
  int           m_cur;
  int           m_last;
  int           m_writes;
  bit           m_wr_pend;
  logic [R-1:0] m_gnt;
  logic [R-1:0] m_ack;
  logic [N-1:0] m_q;
  logic         m_qv;
  int           m_owner;

  always @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      m_cur = -1; m_last = R-1; m_writes = 0; m_wr_pend = 0;
      m_gnt = '0; m_ack = '0; m_q = '0; m_qv = 0; m_owner = 0;
    end else if (m_cur < 0) begin
      m_ack = '0;
      m_gnt = '0;
      for (int k = 1; k <= R; k++)
        if (m_cur < 0 && bus.req[(m_last+k)%R]) m_cur = (m_last+k)%R;
      if (m_cur >= 0) begin
        m_gnt = R'(1) << m_cur;
        m_writes = 0;
        m_wr_pend = 1;
      end
    end else if (m_wr_pend) begin
      m_q = bus.din[m_cur*N +: N];
      m_qv = 1;
      m_owner = m_cur;
      m_last = m_cur;
      m_ack = R'(1) << m_cur;
      m_writes++;
      m_wr_pend = 0;
    end else begin
      bit more;
      m_ack = '0;
`ifdef ARB_LOCK_EN
      more = bus.lock[m_cur] && bus.req[m_cur] && (m_writes < MB);
`else
      more = 0;
`endif
      if (more) m_wr_pend = 1;
      else begin
        m_gnt = '0;
        m_cur = -1;
      end
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic agents();
    for (int i = 0; i < R; i++) begin
      if (bus.ack[i]) begin
        chk("wait_bound", 32'(wt[i] > WMAX), 0);
        wt[i] = 0;
        if ($urandom_range(0, 1) == 1) bus.din[i*N +: N] = N'($urandom);
        else bus.req[i] = 1'b0;
      end else if (bus.req[i]) begin
        wt[i]++;
      end else if ($urandom_range(0, 3) == 0) begin
        bus.req[i] = 1'b1;
        bus.din[i*N +: N] = N'($urandom);
        wt[i] = 0;
`ifdef ARB_LOCK_EN
        bus.lock[i] = ($urandom_range(0, 2) == 0);
`endif
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("gnt", bus.gnt, m_gnt);
    chk("ack", bus.ack, m_ack);
    chk("q", bus.q, m_q);
    chk("q_valid", bus.q_valid, m_qv);
    chk("owner", bus.owner, m_owner);
    chk("busy", bus.busy, 32'(m_cur >= 0));
    chk("ack_sub", 32'((bus.ack & ~bus.gnt) != 0), 0);
    if (auto_en) agents();
  endtask

  task automatic do_reset();
    bus.req = '0;
`ifdef ARB_LOCK_EN
    bus.lock = '0;
`endif
    res_n = 1'b0;
    step();
    step();
    res_n = 1'b1;
  endtask

  function automatic int idx_of(logic [R-1:0] v);
    for (int i = 0; i < R; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    int ids [$];
    int cyc [$];
    int n;
    bus.req = '0;
    bus.din = '0;
`ifdef ARB_LOCK_EN
    bus.lock = '0;
`endif
    #1 res_n = 1'b0;
    step();
    step();
    chk("rst_q", bus.q, 0);
    chk("rst_busy", bus.busy, 0);
    res_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("idle_qv", bus.q_valid, 0);

    // single write from requester 2
    bus.din = 32'h00A5_0000;
    bus.req = 4'b0100;
    step();
    chk("sw_gnt", bus.gnt, 4'b0100);
    step();
    chk("sw_q", bus.q, 8'hA5);
    chk("sw_owner", bus.owner, 2);
    chk("sw_ack", bus.ack, 4'b0100);
    bus.req = '0;
    step();
    chk("sw_busy", bus.busy, 0);
    chk("sw_gnt0", bus.gnt, 0);

    // rotation with all requesting
    do_reset();
    bus.din = 32'h1312_1110;
    bus.req = 4'b1111;
    for (int c = 0; c < 30 && ids.size() < 5; c++) begin
      step();
      if (bus.ack != 0) begin
        ids.push_back(idx_of(bus.ack));
        cyc.push_back(c);
        chk("rot_q", bus.q, 8'h10 + 8'((ids.size()-1) % R));
      end
    end
    chk("rot_cnt", ids.size(), 5);
    n = ids.size();
    for (int i = 0; i < n; i++) chk("rot_id", ids[i], i % R);
    for (int i = 1; i < n; i++) chk("rot_gap", cyc[i] - cyc[i-1], 3);

    // requester 1 re-requests while 3 is pending
    do_reset();
    ids.delete();
    bus.req = 4'b1010;
    for (int c = 0; c < 30 && ids.size() < 3; c++) begin
      step();
      if (bus.ack != 0) ids.push_back(idx_of(bus.ack));
    end
    chk("fair_cnt", ids.size(), 3);
    if (ids.size() == 3) begin
      chk("fair_a", ids[0], 1);
      chk("fair_b", ids[1], 3);
      chk("fair_c", ids[2], 1);
    end

    // reset while in LOAD
    do_reset();
    bus.din = 32'h0000_00FF;
    bus.req = 4'b0001;
    step();
    chk("mr_load_gnt", bus.gnt, 4'b0001);
    res_n = 1'b0;
    bus.req = 4'b0011;
    #1;
    chk("mr_q", bus.q, 0);
    chk("mr_gnt", bus.gnt, 0);
    chk("mr_ack", bus.ack, 0);
    step();
    res_n = 1'b1;
    step();
    chk("mr_first", bus.gnt, 4'b0001);
    bus.req = '0;
    for (int i = 0; i < 4; i++) step();

`ifdef ARB_LOCK_EN
    // locked burst by requester 0
    do_reset();
    ids.delete();
    cyc.delete();
    bus.lock = 4'b0001;
    bus.din = 32'h0000_2211;
    bus.req = 4'b0011;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (bus.gnt[1]) break;
      if (bus.ack[0]) cyc.push_back(c);
      if (cyc.size() > 0 && cyc.size() < MB && !bus.gnt[0]) n++;
    end
    chk("lk_cnt", cyc.size(), MB);
    chk("lk_gnt_gap", n, 0);
    chk("lk_next", bus.gnt, 4'b0010);
    for (int i = 1; i < cyc.size(); i++) chk("lk_gap", cyc[i] - cyc[i-1], 2);
    bus.req = '0;
    bus.lock = '0;
    for (int i = 0; i < 4; i++) step();
`endif

    // random requesters against the model
    do_reset();
    for (int i = 0; i < R; i++) wt[i] = 0;
    auto_en = 1'b1;
    for (int i = 0; i < 3000; i++) step();
    auto_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
